// File: rtl/rvfpm_xif_pipe.sv
// rvfpm_xif_pipe
//   In-order FP coprocessor pipeline executing the bit-exact RV32F move and
//   sign-inject subset (FSGNJ, FSGNJN, FSGNJX, FMV.X.W, FMV.W.X).
//   Instructions are decoded and executed at issue. They then travel through
//   PIPELINE_STAGES registered stages and retire in order over a valid/ready
//   result port. The FP register file is written only at the result
//   handshake. Issue stalls on RAW hazards against any in-flight FP writer,
//   and there is no bypass path.
//
// Ports
//   ck            clock, rising edge
//   rst           synchronous active-high reset; overrides flush and handshakes
//   flush         kills every in-flight instruction at the edge
//   issue_*       valid/ready instruction port (instr word, id tag, int operand)
//   result_*      valid/ready result port (id, data, int write, illegal flag)
//   busy          any stage holds a valid instruction
//   dbg_raddr/dbg_rdata  combinational register file read
module rvfpm_xif_pipe #(
   parameter int FLEN            = 32,
   parameter int XLEN            = 32,
   parameter int NUM_REGS        = 32,
   parameter int PIPELINE_STAGES = 4,
   parameter int X_ID_WIDTH      = 4
) (
   input  logic                        ck,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        issue_valid,
   output logic                        issue_ready,
   input  logic [31:0]                 issue_instr,
   input  logic [X_ID_WIDTH-1:0]       issue_id,
   input  logic [XLEN-1:0]             issue_xdata,
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic [X_ID_WIDTH-1:0]       result_id,
   output logic [XLEN-1:0]             result_data,
   output logic                        result_xwe,
   output logic                        result_exc,
   output logic                        busy,
   input  logic [$clog2(NUM_REGS)-1:0] dbg_raddr,
   output logic [FLEN-1:0]             dbg_rdata
);

   localparam int S  = PIPELINE_STAGES;
   localparam int AW = $clog2(NUM_REGS);

   typedef struct packed {
      logic                  valid;
      logic [X_ID_WIDTH-1:0] id;
      logic [XLEN-1:0]       data;
      logic                  xwe;
      logic                  exc;
      logic                  fwe;   // writes f[rd] at retirement
      logic [4:0]            rd;
   } stage_t;

   stage_t          pipe [S];
   logic [FLEN-1:0] regs [NUM_REGS];

   // Instruction fields
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rd, rs1, rs2;

   assign opcode = issue_instr[6:0];
   assign rd     = issue_instr[11:7];
   assign funct3 = issue_instr[14:12];
   assign rs1    = issue_instr[19:15];
   assign rs2    = issue_instr[24:20];
   assign funct7 = issue_instr[31:25];

   logic rd_ok, rs1_ok, rs2_ok;
   assign rd_ok  = int'(rd)  < NUM_REGS;
   assign rs1_ok = int'(rs1) < NUM_REGS;
   assign rs2_ok = int'(rs2) < NUM_REGS;

   // Operands are read here, at issue; hazard stalls guarantee they are current.
   logic [FLEN-1:0] rs1_val, rs2_val;
   assign rs1_val = rs1_ok ? regs[rs1[AW-1:0]] : '0;
   assign rs2_val = rs2_ok ? regs[rs2[AW-1:0]] : '0;

   logic   is_sgnj, is_mvxw, is_mvwx, legal, use_rs1, use_rs2, sgn;
   stage_t new_stage;

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      is_sgnj   = 1'b0;
      is_mvxw   = 1'b0;
      is_mvwx   = 1'b0;
      sgn       = 1'b0;
      new_stage = '0;
      if (opcode == 7'b1010011 && funct3 == 3'b000 && rs2 == 5'd0) begin
         is_mvxw = (funct7 == 7'b1110000) && rs1_ok;
         is_mvwx = (funct7 == 7'b1111000) && rd_ok;
      end
      if (opcode == 7'b1010011 && funct7 == 7'b0010000 && funct3 <= 3'b010)
         is_sgnj = rd_ok && rs1_ok && rs2_ok;
      legal   = is_sgnj || is_mvxw || is_mvwx;
      use_rs1 = is_sgnj || is_mvxw;
      use_rs2 = is_sgnj;

      new_stage.valid = 1'b1;
      new_stage.id    = issue_id;
      new_stage.rd    = rd;
      if (is_sgnj) begin
         unique case (funct3)
            3'b000:  sgn = rs2_val[FLEN-1];
            3'b001:  sgn = ~rs2_val[FLEN-1];
            default: sgn = rs1_val[FLEN-1] ^ rs2_val[FLEN-1];
         endcase
         new_stage.data = XLEN'({sgn, rs1_val[FLEN-2:0]});
         new_stage.fwe  = 1'b1;
      end else if (is_mvxw) begin
         new_stage.data = XLEN'($signed(rs1_val));
         new_stage.xwe  = 1'b1;
      end else if (is_mvwx) begin
         new_stage.data = XLEN'(issue_xdata[FLEN-1:0]);
         new_stage.fwe  = 1'b1;
      end else if (!legal) begin
         new_stage.exc  = 1'b1;
      end
   end

   // RAW hazard against every valid FP writer, including the one retiring now.
   logic hazard;
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < S; i++) begin
         if (pipe[i].valid && pipe[i].fwe &&
             ((use_rs1 && pipe[i].rd == rs1) || (use_rs2 && pipe[i].rd == rs2)))
            hazard = 1'b1;
      end
   end

   logic adv, accept, retire;
   assign adv         = !(pipe[S-1].valid && !result_ready);
   assign issue_ready = adv && !(issue_valid && hazard) && !flush && !rst;
   assign accept      = issue_valid && issue_ready;
   assign retire      = pipe[S-1].valid && result_ready && !flush && !rst;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // stage samples its predecessor's pre-edge value.
   always_ff @(posedge ck) begin
      if (rst) begin
         for (int i = 0; i < S; i++) pipe[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < S; i++) pipe[i].valid <= 1'b0;
      end else if (adv) begin
         for (int i = S - 1; i > 0; i--) pipe[i] <= pipe[i-1];
         pipe[0] <= accept ? new_stage : '0;
      end
   end

   // NOTE: the register file must read as zero after reset, so it is built
   // from resettable flops rather than a RAM macro.
   always_ff @(posedge ck) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (retire && pipe[S-1].fwe) begin
         regs[pipe[S-1].rd[AW-1:0]] <= pipe[S-1].data[FLEN-1:0];
      end
   end

   assign result_valid = pipe[S-1].valid;
   assign result_id    = pipe[S-1].id;
   assign result_data  = pipe[S-1].data;
   assign result_xwe   = pipe[S-1].xwe;
   assign result_exc   = pipe[S-1].exc;

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < S; i++) busy = busy | pipe[i].valid;
   end

   assign dbg_rdata = (int'(dbg_raddr) < NUM_REGS) ? regs[dbg_raddr] : '0;

endmodule
